// File: rtl/se_arbiter.sv
// se_arbiter
// Round-robin arbiter and sequencer that shares a single SE execution unit
// between two requesters. One operation is in flight at a time: it is
// accepted from a requester, issued to the SE unit, the SE result is
// captured, and the result is returned only to the requester that issued it.
//
// Optional feature macro: SE_ARB_LATENCY_CHECK_EN
//   Defined   : measures SE latency of every operation and raises a sticky
//               flag when a latency differs from the first one after reset.
//   Undefined : io_lat_cycles / io_lat_mismatch are tied to zero.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   io_reqN_*               operation from requester N (inst/op1/op2/cond,
//                           valid in, ready out), N = 0,1
//   io_respN_*              result to requester N (result/valid out, ready in)
//   io_se_*                 operation to the SE unit and its result back
//   io_lat_cycles           latency of the last completed operation
//   io_lat_mismatch         sticky latency-variation flag
module se_arbiter #(
   parameter int LAT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [7:0]       io_req0_inst,
   input  logic [127:0]     io_req0_op1,
   input  logic [127:0]     io_req0_op2,
   input  logic [127:0]     io_req0_cond,
   input  logic             io_req0_valid,
   output logic             io_req0_ready,
   input  logic [7:0]       io_req1_inst,
   input  logic [127:0]     io_req1_op1,
   input  logic [127:0]     io_req1_op2,
   input  logic [127:0]     io_req1_cond,
   input  logic             io_req1_valid,
   output logic             io_req1_ready,
   output logic [127:0]     io_resp0_result,
   output logic             io_resp0_valid,
   input  logic             io_resp0_ready,
   output logic [127:0]     io_resp1_result,
   output logic             io_resp1_valid,
   input  logic             io_resp1_ready,
   output logic [7:0]       io_se_inst,
   output logic [127:0]     io_se_op1,
   output logic [127:0]     io_se_op2,
   output logic [127:0]     io_se_cond,
   output logic             io_se_in_valid,
   input  logic             io_se_in_ready,
   input  logic [127:0]     io_se_out_result,
   input  logic             io_se_out_valid,
   output logic             io_se_out_ready,
   output logic [LAT_W-1:0] io_lat_cycles,
   output logic             io_lat_mismatch
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t       state;
   state_t       state_next;
   logic         prio;
   logic         owner;
   logic         grant;
   logic [7:0]   inst_q;
   logic [127:0] op1_q;
   logic [127:0] op2_q;
   logic [127:0] cond_q;
   logic [127:0] result_q;
   logic         req_fire;
   logic         issue_fire;
   logic         se_fire;
   logic         resp_fire;

   // Under contention the priority pointer decides; otherwise the lone
   // valid requester wins. With no request at all grant is 0, but the
   // ready terms below also require valid, so nothing is accepted.
   always_comb begin
      grant = io_req1_valid;
      if (io_req0_valid && io_req1_valid) begin
         grant = prio;
      end
   end

   assign io_req0_ready = (state == IDLE) && io_req0_valid && !grant;
   assign io_req1_ready = (state == IDLE) && io_req1_valid && grant;

   assign req_fire   = io_req0_ready || io_req1_ready;
   assign issue_fire = (state == ISSUE) && io_se_in_ready;
   assign se_fire    = (state == WAIT) && io_se_out_valid;
   assign resp_fire  = (state == RESP) && (owner ? io_resp1_ready : io_resp0_ready);

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: one operation walks IDLE -> ISSUE -> WAIT -> RESP.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req_fire)        state_next = ISSUE;
         ISSUE:   if (io_se_in_ready)  state_next = WAIT;
         WAIT:    if (io_se_out_valid) state_next = RESP;
         RESP:    if (resp_fire)       state_next = IDLE;
         default:                      state_next = IDLE;
      endcase
   end

   // Operation, owner and result capture. The pointer moves to the other
   // requester only once the result has been handed back, so a requester
   // that waited through a busy period is served next.
   always_ff @(posedge clock) begin
      if (reset) begin
         prio     <= 1'b0;
         owner    <= 1'b0;
         inst_q   <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         cond_q   <= '0;
         result_q <= '0;
      end else begin
         if (req_fire) begin
            owner  <= grant;
            inst_q <= grant ? io_req1_inst : io_req0_inst;
            op1_q  <= grant ? io_req1_op1  : io_req0_op1;
            op2_q  <= grant ? io_req1_op2  : io_req0_op2;
            cond_q <= grant ? io_req1_cond : io_req0_cond;
         end
         if (se_fire) begin
            result_q <= io_se_out_result;
         end
         if (resp_fire) begin
            prio <= ~owner;
         end
      end
   end

   assign io_se_inst      = inst_q;
   assign io_se_op1       = op1_q;
   assign io_se_op2       = op2_q;
   assign io_se_cond      = cond_q;
   assign io_se_in_valid  = (state == ISSUE);
   assign io_se_out_ready = (state == WAIT);
   assign io_resp0_result = result_q;
   assign io_resp1_result = result_q;
   assign io_resp0_valid  = (state == RESP) && !owner;
   assign io_resp1_valid  = (state == RESP) && owner;

`ifdef SE_ARB_LATENCY_CHECK_EN
   logic [LAT_W-1:0] lat_cnt;
   logic [LAT_W-1:0] lat_q;
   logic [LAT_W-1:0] lat_ref;
   logic [LAT_W-1:0] lat_now;
   logic             ref_valid;
   logic             mismatch_q;

   // Latency counts WAIT cycles including the acceptance cycle; the +1
   // saturates together with the counter.
   assign lat_now = (lat_cnt == '1) ? lat_cnt : lat_cnt + LAT_W'(1);

   // The first completed operation after reset becomes the reference;
   // any later difference latches the mismatch flag until reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         lat_cnt    <= '0;
         lat_q      <= '0;
         lat_ref    <= '0;
         ref_valid  <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         if (issue_fire) begin
            lat_cnt <= '0;
         end else if ((state == WAIT) && (lat_cnt != '1)) begin
            lat_cnt <= lat_cnt + LAT_W'(1);
         end
         if (se_fire) begin
            lat_q <= lat_now;
            if (!ref_valid) begin
               lat_ref   <= lat_now;
               ref_valid <= 1'b1;
            end else if (lat_now != lat_ref) begin
               mismatch_q <= 1'b1;
            end
         end
      end
   end

   assign io_lat_cycles   = lat_q;
   assign io_lat_mismatch = mismatch_q;
`else
   assign io_lat_cycles   = '0;
   assign io_lat_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_se_arbiter.sv
// tb_se_arbiter
// Self-checking bench for se_arbiter. A behavioural SE unit with
// programmable issue stall and result latency answers every issue; a
// scoreboard records the expected owner and result of each accepted request
// and compares them when the response handshake happens.
module tb_se_arbiter;

   localparam int LAT_W = 16;
`ifdef SE_ARB_LATENCY_CHECK_EN
   localparam bit LAT_EN = 1'b1;
`else
   localparam bit LAT_EN = 1'b0;
`endif

   logic             clock = 1'b0;
   logic             reset;
   logic [7:0]       req_inst [2];
   logic [127:0]     req_op1  [2];
   logic [127:0]     req_op2  [2];
   logic [127:0]     req_cond [2];
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0]       resp_valid;
   logic [1:0]       resp_ready;
   logic [127:0]     resp_result0;
   logic [127:0]     resp_result1;
   logic [7:0]       se_inst;
   logic [127:0]     se_op1;
   logic [127:0]     se_op2;
   logic [127:0]     se_cond;
   logic             se_in_valid;
   logic             se_in_ready;
   logic [127:0]     se_out_result;
   logic             se_out_valid;
   logic             se_out_ready;
   logic [LAT_W-1:0] lat_cycles;
   logic             lat_mismatch;

   se_arbiter #(.LAT_W(LAT_W)) dut (
      .clock           (clock),
      .reset           (reset),
      .io_req0_inst    (req_inst[0]),
      .io_req0_op1     (req_op1[0]),
      .io_req0_op2     (req_op2[0]),
      .io_req0_cond    (req_cond[0]),
      .io_req0_valid   (req_valid[0]),
      .io_req0_ready   (req_ready[0]),
      .io_req1_inst    (req_inst[1]),
      .io_req1_op1     (req_op1[1]),
      .io_req1_op2     (req_op2[1]),
      .io_req1_cond    (req_cond[1]),
      .io_req1_valid   (req_valid[1]),
      .io_req1_ready   (req_ready[1]),
      .io_resp0_result (resp_result0),
      .io_resp0_valid  (resp_valid[0]),
      .io_resp0_ready  (resp_ready[0]),
      .io_resp1_result (resp_result1),
      .io_resp1_valid  (resp_valid[1]),
      .io_resp1_ready  (resp_ready[1]),
      .io_se_inst      (se_inst),
      .io_se_op1       (se_op1),
      .io_se_op2       (se_op2),
      .io_se_cond      (se_cond),
      .io_se_in_valid  (se_in_valid),
      .io_se_in_ready  (se_in_ready),
      .io_se_out_result(se_out_result),
      .io_se_out_valid (se_out_valid),
      .io_se_out_ready (se_out_ready),
      .io_lat_cycles   (lat_cycles),
      .io_lat_mismatch (lat_mismatch)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic         who;
      logic [127:0] res;
   } sb_t;

   sb_t          sb_q[$];
   int           grant_q[$];
   int           vectors = 0;
   int           miscompares = 0;
   int           cyc = 0;
   int           se_lat = 4;
   int           se_stall = 0;
   int           resp_hold[2] = '{0, 0};
   int           resp_cycles[2] = '{0, 0};
   int           resp_count = 0;
   int           se_in_cycles = 0;
   bit           accepted[2] = '{1'b0, 1'b0};
   logic [127:0] last_result[2];

   always @(posedge clock) cyc <= cyc + 1;

   // Compares one observed value against the bench's own expectation.
   task automatic checkOutput(input string tag, input logic [127:0] actual,
                              input logic [127:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Function of the behavioural SE unit.
   function automatic logic [127:0] seFunc(input logic [7:0] i, input logic [127:0] a,
                                           input logic [127:0] b, input logic [127:0] c);
      case (i)
         8'h01:   return a * b;
         8'h02:   return a - b;
         default: return (a ^ c) + b;
      endcase
   endfunction

   // Behavioural SE unit: stalls the issue by se_stall cycles, then raises
   // its result se_lat cycles after the issue handshake. An unaccepted
   // result is abandoned after a few cycles.
   initial begin
      logic [127:0] res;
      bit           hs;
      se_in_ready   = 1'b0;
      se_out_valid  = 1'b0;
      se_out_result = '0;
      forever begin
         @(negedge clock);
         if (se_in_valid && !reset) begin
            repeat (se_stall) @(negedge clock);
            se_in_ready = 1'b1;
            res = seFunc(se_inst, se_op1, se_op2, se_cond);
            @(negedge clock);
            se_in_ready = 1'b0;
            repeat (se_lat - 1) @(negedge clock);
            se_out_valid  = 1'b1;
            se_out_result = res;
            for (int k = 0; k < 4; k++) begin
               #1 hs = se_out_ready;
               @(negedge clock);
               if (hs) break;
            end
            se_out_valid = 1'b0;
         end
      end
   end

   // Monitor: samples 2 time units before each rising edge.
   initial begin
      logic         prev_in_valid = 1'b0;
      logic         prev_in_hs = 1'b0;
      logic [7:0]   prev_inst = '0;
      logic [127:0] prev_op1 = '0, prev_op2 = '0, prev_cond = '0;
      logic [1:0]   prev_resp_wait = '0;
      logic [127:0] prev_res = '0;
      logic [127:0] cur_res;
      int           acc_cycle = 0, seacc_cycle = 0;
      bit           issue_pending = 1'b0, resp_pending = 1'b0;
      sb_t          e;
      forever begin
         @(negedge clock);
         #3;
         if (reset) begin
            prev_in_valid  = 1'b0;
            prev_resp_wait = '0;
            issue_pending  = 1'b0;
            resp_pending   = 1'b0;
         end else begin
            if (prev_in_valid && !prev_in_hs) begin
               checkOutput("se_in_valid hold", 128'(se_in_valid), 128'd1);
               checkOutput("se_inst hold", 128'(se_inst), 128'(prev_inst));
               checkOutput("se_op1 hold", se_op1, prev_op1);
               checkOutput("se_op2 hold", se_op2, prev_op2);
               checkOutput("se_cond hold", se_cond, prev_cond);
            end
            if (se_in_valid || se_out_ready || (resp_valid != 2'b00))
               checkOutput("req_ready while busy", 128'(req_ready), 128'd0);
            if (issue_pending && se_in_valid) begin
               checkOutput("issue latency", 128'(cyc - acc_cycle), 128'd1);
               issue_pending = 1'b0;
            end
            if (resp_pending && (resp_valid != 2'b00)) begin
               checkOutput("resp latency", 128'(cyc - seacc_cycle), 128'd1);
               resp_pending = 1'b0;
            end
            for (int n = 0; n < 2; n++) begin
               cur_res = (n == 1) ? resp_result1 : resp_result0;
               if (prev_resp_wait[n]) begin
                  checkOutput("resp valid hold", 128'(resp_valid[n]), 128'd1);
                  checkOutput("resp result hold", cur_res, prev_res);
               end
               if (req_valid[n] && req_ready[n]) begin
                  e.who = n[0];
                  e.res = seFunc(req_inst[n], req_op1[n], req_op2[n], req_cond[n]);
                  sb_q.push_back(e);
                  grant_q.push_back(n);
                  accepted[n]   = 1'b1;
                  acc_cycle     = cyc;
                  issue_pending = 1'b1;
               end
               if (resp_valid[n]) resp_cycles[n]++;
               if (resp_valid[n] && resp_ready[n]) begin
                  checkOutput("scoreboard occupancy", 128'(sb_q.size() != 0), 128'd1);
                  if (sb_q.size() != 0) begin
                     e = sb_q.pop_front();
                     checkOutput("resp owner", 128'(n), 128'(e.who));
                     checkOutput("resp result", cur_res, e.res);
                  end
                  last_result[n] = cur_res;
                  resp_count++;
               end
            end
            if (se_out_valid && se_out_ready) begin
               seacc_cycle  = cyc;
               resp_pending = 1'b1;
            end
            if (se_in_valid) se_in_cycles++;
            prev_in_valid = se_in_valid;
            prev_in_hs    = se_in_ready;
            prev_inst     = se_inst;
            prev_op1      = se_op1;
            prev_op2      = se_op2;
            prev_cond     = se_cond;
            prev_res      = (resp_valid[1]) ? resp_result1 : resp_result0;
            prev_resp_wait = resp_valid & ~resp_ready;
         end
      end
   end

   // Presents an operation on requester n; caller is at a falling edge.
   task automatic setReq(input int n, input logic [7:0] i, input logic [127:0] a,
                         input logic [127:0] b, input logic [127:0] c);
      req_inst[n]  = i;
      req_op1[n]   = a;
      req_op2[n]   = b;
      req_cond[n]  = c;
      req_valid[n] = 1'b1;
   endtask

   // Drives pending requests and response backpressure until every request
   // is accepted and every result returned, within a cycle budget.
   task automatic applyStimulus(input int max_cycles);
      int c = 0;
      while (((req_valid != 2'b00) || (sb_q.size() != 0)) && (c < max_cycles)) begin
         @(negedge clock);
         c++;
         for (int n = 0; n < 2; n++) begin
            if (accepted[n]) begin
               req_valid[n] = 1'b0;
               accepted[n]  = 1'b0;
            end
            if (resp_valid[n] && !resp_ready[n]) begin
               if (resp_hold[n] > 0) resp_hold[n]--;
               else resp_ready[n] = 1'b1;
            end
         end
      end
      checkOutput("drain timeout", 128'((req_valid != 2'b00) || (sb_q.size() != 0)), 128'd0);
   endtask

   task automatic resetPulse();
      @(negedge clock);
      reset = 1'b1;
      req_valid = '0;
      accepted = '{1'b0, 1'b0};
      @(negedge clock);
      reset = 1'b0;
      sb_q.delete();
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " req_ready"}, 128'(req_ready), 128'd0);
      checkOutput({tag, " resp_valid"}, 128'(resp_valid), 128'd0);
      checkOutput({tag, " se_in_valid"}, 128'(se_in_valid), 128'd0);
      checkOutput({tag, " se_out_ready"}, 128'(se_out_ready), 128'd0);
      checkOutput({tag, " se_op1"}, se_op1, 128'd0);
      checkOutput({tag, " se_inst"}, 128'(se_inst), 128'd0);
      checkOutput({tag, " resp_result"}, resp_result0, 128'd0);
      checkOutput({tag, " lat_cycles"}, 128'(lat_cycles), 128'd0);
      checkOutput({tag, " lat_mismatch"}, 128'(lat_mismatch), 128'd0);
   endtask

   initial begin
      int exp_grants[9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
      int r0, r1, s0, c;
      int lats[4] = '{4, 4, 7, 4};
      reset      = 1'b1;
      req_valid  = '0;
      resp_ready = 2'b11;
      for (int n = 0; n < 2; n++) begin
         req_inst[n] = '0; req_op1[n] = '0; req_op2[n] = '0; req_cond[n] = '0;
      end
      repeat (3) @(negedge clock);
      checkResetValues("reset");
      reset = 1'b0;

      // Single requester: 3 * 5 with a 4-cycle SE latency.
      se_lat = 4;
      setReq(0, 8'h01, 128'd3, 128'd5, 128'd0);
      applyStimulus(100);
      checkOutput("single result", last_result[0], 128'd15);
      checkOutput("single resp1 never", 128'(resp_cycles[1]), 128'd0);
      checkOutput("single resp0 cycles", 128'(resp_cycles[0]), 128'd1);
      checkOutput("single lat_cycles", 128'(lat_cycles), LAT_EN ? 128'd4 : 128'd0);

      // Contention after reset, twice, then one lone req0 and contention.
      resetPulse();
      checkOutput("pulse lat_cycles", 128'(lat_cycles), 128'd0);
      grant_q.delete();
      setReq(0, 8'h02, 128'd100, 128'd30, 128'd0);
      setReq(1, 8'h03, 128'hF0, 128'd7, 128'h0F);
      applyStimulus(200);
      setReq(0, 8'h01, 128'd11, 128'd13, 128'd0);
      setReq(1, 8'h02, 128'd50, 128'd8, 128'd0);
      applyStimulus(200);
      setReq(0, 8'h03, 128'd1, 128'd2, 128'd4);
      applyStimulus(100);
      setReq(0, 8'h02, 128'd9, 128'd4, 128'd0);
      setReq(1, 8'h01, 128'd6, 128'd7, 128'd0);
      applyStimulus(200);

      // Backpressure: issue stalled 5 cycles, response to req1 held off
      // 3 cycles, req0 waiting throughout (pointer now favours req1).
      r1 = resp_cycles[1];
      s0 = se_in_cycles;
      se_stall = 5;
      resp_ready[1] = 1'b0;
      resp_hold[1]  = 3;
      setReq(1, 8'h03, 128'h1234, 128'h55, 128'hFF);
      setReq(0, 8'h01, 128'd21, 128'd2, 128'd0);
      applyStimulus(200);
      se_stall = 0;
      checkOutput("bp resp1 valid cycles", 128'(resp_cycles[1] - r1), 128'd4);
      checkOutput("bp se_in_valid cycles", 128'(se_in_cycles - s0), 128'd12);
      checkOutput("bp lat_cycles", 128'(lat_cycles), LAT_EN ? 128'd4 : 128'd0);

      checkOutput("grant count", 128'(grant_q.size()), 128'd9);
      for (int k = 0; k < 9 && grant_q.size() != 0; k++)
         checkOutput($sformatf("grant order %0d", k), 128'(grant_q.pop_front()), 128'(exp_grants[k]));

      // Reset in WAIT; the SE result arrives one cycle after reset.
      se_lat = 3;
      @(negedge clock);
      setReq(0, 8'h02, 128'd77, 128'd7, 128'd0);
      c = 0;
      while (!se_out_ready && c < 50) begin
         @(negedge clock);
         c++;
         if (accepted[0]) begin req_valid[0] = 1'b0; accepted[0] = 1'b0; end
      end
      checkOutput("reached WAIT", 128'(se_out_ready), 128'd1);
      reset = 1'b1;
      @(negedge clock);
      checkResetValues("midop");
      reset = 1'b0;
      sb_q.delete();
      r0 = resp_count;
      r1 = resp_cycles[0] + resp_cycles[1];
      repeat (8) @(negedge clock);
      checkOutput("midop no response", 128'(resp_count - r0), 128'd0);
      checkOutput("midop no resp valid", 128'(resp_cycles[0] + resp_cycles[1] - r1), 128'd0);
      se_lat = 4;
      r0 = resp_count;
      setReq(1, 8'h01, 128'd12, 128'd12, 128'd0);
      applyStimulus(100);
      checkOutput("post reset served", 128'(resp_count - r0), 128'd1);
      checkOutput("post reset result", last_result[1], 128'd144);

      // Latency leak: 4, 4, 7, 4.
      resetPulse();
      for (int k = 0; k < 4; k++) begin
         se_lat = lats[k];
         setReq(k % 2, 8'(k), 128'($urandom), 128'($urandom), 128'($urandom));
         applyStimulus(100);
         checkOutput($sformatf("leak lat_cycles %0d", k), 128'(lat_cycles),
                     LAT_EN ? 128'(lats[k]) : 128'd0);
         checkOutput($sformatf("leak mismatch %0d", k), 128'(lat_mismatch),
                     (LAT_EN && k >= 2) ? 128'd1 : 128'd0);
      end

      repeat (3) @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/se_arbiter.md
# se_arbiter

Round-robin arbiter and sequencer that shares one SE execution unit (128-bit operands, 8-bit instruction, ready/valid in and out) between two requesters. It accepts one operation at a time, issues it to the SE unit, and returns the result only to the requester that issued it. With the latency-check feature compiled in, it measures per-operation SE latency and flags any variation, which is a timing-leak indicator for self-composition benches.

## Interface
Parameters:
- `LAT_W`, default 16: width of the latency counter.

Ports. Clock and reset come first. Reset is synchronous and active-high.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `io_reqN_inst`  in  8  instruction from requester N, N∈{0,1}.
- `io_reqN_op1`, `io_reqN_op2`, `io_reqN_cond`  in  128 each  operands from requester N.
- `io_reqN_valid`  in  1  requester N has an operation.
- `io_reqN_ready`  out  1  arbiter accepts requester N's operation this cycle.
- `io_respN_result`  out  128  result returned to requester N.
- `io_respN_valid`  out  1  result for N is valid.
- `io_respN_ready`  in  1  requester N takes the result.
- `io_se_inst`, `io_se_op1`, `io_se_op2`, `io_se_cond`  out  8/128/128/128  operation driven to the SE unit.
- `io_se_in_valid`  out  1  issue request to the SE unit.
- `io_se_in_ready`  in  1  SE unit accepts the issue.
- `io_se_out_result`  in  128  SE unit result.
- `io_se_out_valid`  in  1  SE unit result is valid.
- `io_se_out_ready`  out  1  arbiter takes the SE result.
- `io_lat_cycles`  out  LAT_W  latency of the last completed operation.
- `io_lat_mismatch`  out  1  sticky flag: a latency differed from the reference latency.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- Priority pointer `prio` resets to 0.
- Grant rule in IDLE:
  - if both requesters are valid, grant goes to `prio`;
  - otherwise grant goes to the single valid requester.
- `io_reqN_ready` = (state==IDLE) & (grant==N). It is combinational and at most one is high.
- On a request handshake:
  - latch inst/op1/op2/cond and `owner`=N;
  - go to ISSUE.
- ISSUE:
  - `io_se_in_valid`=1, with the `io_se_*` operand outputs driven from the latched registers;
  - on `io_se_in_ready`, go to WAIT.
- WAIT:
  - `io_se_out_ready`=1;
  - on `io_se_out_valid`, latch the result and go to RESP.
- RESP:
  - `io_resp[owner]_valid`=1 and the other response valid is 0;
  - on `io_resp[owner]_ready`, set `prio`←~owner and go to IDLE.
- Both `io_respN_result` outputs drive the latched result. They are only meaningful while the matching valid is high.
- Operand outputs hold their latched values outside ISSUE.
- A request that is valid while the arbiter is busy waits; it is never dropped.
- Reset mid-operation discards the latched operation:
  - FSM returns to IDLE, `prio`=0;
  - any SE result that arrives after reset is ignored because `io_se_out_ready`=0 in IDLE.

## Timing
- Reset values: all ready/valid outputs are 0, the operand and result registers are 0, `io_lat_cycles`=0 and `io_lat_mismatch`=0.
- A request accepted in cycle t gives `io_se_in_valid`=1 in cycle t+1.
- An SE result accepted in cycle u gives `io_respN_valid`=1 in cycle u+1.
- Minimum request-to-next-request turnaround is 4 cycles when the SE unit and requester respond immediately.
- The arbiter adds no combinational path from `io_se_*` inputs to requester outputs. All response outputs are registered.

## Configuration
- Macro: `SE_ARB_LATENCY_CHECK_EN`.
- Defined:
  - a LAT_W counter clears on the issue handshake and increments every cycle in WAIT;
  - on SE result acceptance, `io_lat_cycles` = the counter value plus 1;
  - the first completed operation after reset stores the reference latency;
  - any later operation with a different latency sets `io_lat_mismatch`, which stays set until reset;
  - the counter saturates at all-ones.
- Undefined: `io_lat_cycles` and `io_lat_mismatch` are tied to 0 and no counter logic exists.

## Test plan
- Single requester: req0 sends inst=0x01, op1=3, op2=5. The SE model answers 15 after 4 cycles. Required: `io_resp0_valid` with result 15, `io_resp1_valid` never asserts, `io_lat_cycles`=4.
- Simultaneous requests after reset: req0 and req1 both valid. Required: req0 is granted first and req1 second, and the next contention grants req0 again only after req1 has been served (alternation).
- Backpressure: hold `io_se_in_ready`=0 for 5 cycles, then hold `io_resp1_ready`=0 for 3 cycles. Required: `io_se_in_valid` and the operands stay stable throughout, the result is held, and neither requester gets ready until RESP completes.
- Reset mid-operation: assert reset in WAIT, then the SE model returns its result a cycle later. Required: all outputs return to reset values, no response is delivered, and a fresh req1 is then served normally.
- Latency leak (macro defined): ops with SE latency 4, 4, then 7. Required: `io_lat_mismatch` is 0 after the first two ops and 1 after the third, and it stays 1 after a further latency-4 op.
- Macro undefined: repeat the latency-leak stimulus. Required: `io_lat_cycles` and `io_lat_mismatch` stay 0 and the results are correct.
